// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } ctrlState_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the instruction in ID.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_Rd,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UsesRt,
  output logic             LoadUse
);

  logic rsMatch;
  logic rtMatch;

  assign rsMatch = (EX_Rd == ID_Rs);
  assign rtMatch = ID_UsesRt && (EX_Rd == ID_Rt);

  // A load into the hard-wired zero register never creates a dependency.
  assign LoadUse = EX_MemRead && (EX_Rd != REG_ZERO) && (rsMatch || rtMatch);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush scheduler for the five-stage pipeline: memory-wait freeze,
// branch flush and load-use stall, plus saturating performance counters.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_Rd,
  input  logic             EX_BranchTaken,
  input  logic             MEM_MemOp,
  input  logic             DMemReady,
  output logic             DMemReq,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Write,
  output logic             IDEX_Flush,
  output logic             EXMEM_Write,
  output logic             MEMWB_Bubble,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  ctrlState_t        state;
  logic [WAIT_W-1:0] waitCnt;
  logic              loadUse;
  logic              freeze;
  logic              branchEv;
  logic              loadUseEv;

  hazard_detect uHazard (
    .EX_MemRead (EX_MemRead),
    .EX_Rd      (EX_Rd),
    .ID_Rs      (ID_Rs),
    .ID_Rt      (ID_Rt),
    .ID_UsesRt  (ID_UsesRt),
    .LoadUse    (loadUse)
  );

  // Event resolution with priority freeze > branch > load-use.
  always_comb begin
    freeze    = 1'b0;
    branchEv  = 1'b0;
    loadUseEv = 1'b0;
    if (Reset) begin
      if (state == RUN) begin
        freeze = MEM_MemOp && !DMemReady;
      end else begin
        freeze = !DMemReady;
      end
      branchEv  = !freeze && EX_BranchTaken;
      loadUseEv = !freeze && !EX_BranchTaken && loadUse;
    end
  end

  // Pipeline-register controls; the reset values double as the freeze values.
  always_comb begin
    DMemReq      = 1'b0;
    PCWrite      = 1'b0;
    IFID_Write   = 1'b0;
    IFID_Flush   = 1'b0;
    IDEX_Write   = 1'b0;
    IDEX_Flush   = 1'b0;
    EXMEM_Write  = 1'b0;
    MEMWB_Bubble = 1'b1;
    if (Reset) begin
      DMemReq = (state == WAIT) || MEM_MemOp;
      if (!freeze) begin
        PCWrite      = 1'b1;
        IFID_Write   = 1'b1;
        IDEX_Write   = 1'b1;
        EXMEM_Write  = 1'b1;
        MEMWB_Bubble = 1'b0;
        if (branchEv) begin
          IFID_Flush = 1'b1;
          IDEX_Flush = 1'b1;
        end else if (loadUseEv) begin
          PCWrite    = 1'b0;
          IFID_Write = 1'b0;
          IDEX_Flush = 1'b1;
        end
      end
    end
  end

  // FSM, wait counter, sticky timeout and performance counters.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state       <= RUN;
      waitCnt     <= '0;
      MemTimeout  <= 1'b0;
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (state == RUN) begin
        if (MEM_MemOp && !DMemReady) begin
          state   <= WAIT;
          waitCnt <= '0;
        end
      end else begin
        if (DMemReady) begin
          state <= RUN;
        end
        if (waitCnt != WAIT_MAX) begin
          waitCnt <= waitCnt + WAIT_W'(1);
        end
        // The increment that lands on MAX_WAIT raises the sticky flag.
        if (waitCnt >= WAIT_MAX - WAIT_W'(1)) begin
          MemTimeout <= 1'b1;
        end
      end

      if ((freeze || loadUseEv) && (StallCycles != CNT_MAX)) begin
        StallCycles <= StallCycles + CNT_W'(1);
      end
      if (branchEv && (FlushCount != CNT_MAX)) begin
        FlushCount <= FlushCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed-vector scoreboard bench for pipeline_stall_controller.
module tb_pipeline_stall_controller;

  logic        Clk;
  logic        Reset;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        ID_UsesRt;
  logic        EX_MemRead;
  logic [4:0]  EX_Rd;
  logic        EX_BranchTaken;
  logic        MEM_MemOp;
  logic        DMemReady;
  logic        DMemReq;
  logic        PCWrite;
  logic        IFID_Write;
  logic        IFID_Flush;
  logic        IDEX_Write;
  logic        IDEX_Flush;
  logic        EXMEM_Write;
  logic        MEMWB_Bubble;
  logic        MemTimeout;
  logic [15:0] StallCycles;
  logic [15:0] FlushCount;

  // Control vector order: DMemReq PCWrite IFID_Write IFID_Flush IDEX_Write IDEX_Flush EXMEM_Write MEMWB_Bubble
  localparam logic [7:0] RST  = 8'b0000_0001;
  localparam logic [7:0] DEF  = 8'b0110_1010;
  localparam logic [7:0] DEFM = 8'b1110_1010;
  localparam logic [7:0] FRZ  = 8'b1000_0001;
  localparam logic [7:0] BR   = 8'b0111_1110;
  localparam logic [7:0] LU   = 8'b0000_1110;

  typedef struct {
    logic [7:0] ctrl;
    int         stall;
    int         flush;
    logic       tmo;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  pipeline_stall_controller #(.MAX_WAIT(16), .CNT_W(16)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .ID_Rs          (ID_Rs),
    .ID_Rt          (ID_Rt),
    .ID_UsesRt      (ID_UsesRt),
    .EX_MemRead     (EX_MemRead),
    .EX_Rd          (EX_Rd),
    .EX_BranchTaken (EX_BranchTaken),
    .MEM_MemOp      (MEM_MemOp),
    .DMemReady      (DMemReady),
    .DMemReq        (DMemReq),
    .PCWrite        (PCWrite),
    .IFID_Write     (IFID_Write),
    .IFID_Flush     (IFID_Flush),
    .IDEX_Write     (IDEX_Write),
    .IDEX_Flush     (IDEX_Flush),
    .EXMEM_Write    (EXMEM_Write),
    .MEMWB_Bubble   (MEMWB_Bubble),
    .MemTimeout     (MemTimeout),
    .StallCycles    (StallCycles),
    .FlushCount     (FlushCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Monitor: every cycle with a queued expectation is checked mid-cycle.
  always @(negedge Clk) begin
    exp_t       e;
    logic [7:0] act;
    if (expQ.size() > 0) begin
      e   = expQ.pop_front();
      act = {DMemReq, PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Write, MEMWB_Bubble};
      total++;
      if (act !== e.ctrl) begin
        bad++;
        $display("FAIL ctrl @%0t: got %b want %b", $time, act, e.ctrl);
      end
      total++;
      if (int'(StallCycles) != e.stall || $isunknown(StallCycles)) begin
        bad++;
        $display("FAIL StallCycles @%0t: got %0d want %0d", $time, StallCycles, e.stall);
      end
      total++;
      if (int'(FlushCount) != e.flush || $isunknown(FlushCount)) begin
        bad++;
        $display("FAIL FlushCount @%0t: got %0d want %0d", $time, FlushCount, e.flush);
      end
      total++;
      if (MemTimeout !== e.tmo) begin
        bad++;
        $display("FAIL MemTimeout @%0t: got %b want %b", $time, MemTimeout, e.tmo);
      end
    end
  end

  // Drive one cycle of inputs and queue its expected response.
  task automatic cyc(input logic rst, input logic memRead, input logic [4:0] rd,
                     input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                     input logic br, input logic memOp, input logic rdy,
                     input logic [7:0] ec, input int es, input int ef, input logic et,
                     input logic chk);
    exp_t e;
    Reset          = rst;
    EX_MemRead     = memRead;
    EX_Rd          = rd;
    ID_Rs          = rs;
    ID_Rt          = rt;
    ID_UsesRt      = usesRt;
    EX_BranchTaken = br;
    MEM_MemOp      = memOp;
    DMemReady      = rdy;
    if (chk) begin
      e.ctrl  = ec;
      e.stall = es;
      e.flush = ef;
      e.tmo   = et;
      expQ.push_back(e);
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset, then idle.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, RST, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, RST, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, DEF, 0, 0, 0, 1);
    // Load-use on Rs stalls exactly one cycle.
    cyc(1, 1, 5, 5, 0, 0, 0, 0, 1, LU,  0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, DEF, 1, 0, 0, 1);
    // Load into r0 and an unread Rt match are not hazards.
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 1, DEF, 1, 0, 0, 1);
    cyc(1, 1, 7, 3, 7, 0, 0, 0, 1, DEF, 1, 0, 0, 1);
    cyc(1, 1, 7, 3, 7, 1, 0, 0, 1, LU,  1, 0, 0, 1);
    // Single-cycle memory access: request but no stall.
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, DEFM, 2, 0, 0, 1);
    // Three-cycle wait; branch and load-use ignored while frozen.
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  2, 0, 0, 1);
    cyc(1, 1, 5, 5, 0, 0, 1, 1, 0, FRZ,  3, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,  4, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, DEFM, 5, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, DEF,  5, 0, 0, 1);
    // Branch with a coincident load-use: flush only.
    cyc(1, 1, 5, 5, 0, 0, 1, 0, 1, BR,  5, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, DEF, 5, 1, 0, 1);
    // Twenty low cycles: timeout visible after the 16th WAIT cycle.
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 5, 1, 0, 1);
    for (int i = 1; i <= 19; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 5 + i, 1, (i >= 17), 1);
    end
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, DEFM, 25, 1, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, DEF,  25, 1, 1, 1);
    // Reset in the middle of a wait drops the request at once.
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 25, 1, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 26, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, RST, 27, 1, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, DEF, 0, 0, 0, 1);
    cyc(1, 1, 9, 2, 9, 1, 0, 0, 1, LU,  0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, DEF, 1, 0, 0, 1);

    @(negedge Clk);
    #1;
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central stall/flush scheduler for the five-stage pipeline. Sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Resolves three events:
- variable-latency data-memory waits in MEM;
- load-use hazards between ID and EX;
- taken branches resolved in EX.

It owns the data-memory request handshake and keeps saturating performance counters plus a sticky memory-timeout flag.

## Interface
Parameters:
- MAX_WAIT, 16, wait cycles in WAIT before MemTimeout sets.
- CNT_W, 16, width of performance counters.

Ports:
- Clk  in  1  pipeline clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset.
- ID_Rs  in  5  source register of instruction in ID.
- ID_Rt  in  5  second source register in ID.
- ID_UsesRt  in  1  ID instruction reads Rt.
- EX_MemRead  in  1  EX instruction is a load.
- EX_Rd  in  5  destination register of EX instruction.
- EX_BranchTaken  in  1  branch resolved taken in EX.
- MEM_MemOp  in  1  MEM instruction is a load or store.
- DMemReady  in  1  data memory completes the access this cycle.
- DMemReq  out  1  data-memory request.
- PCWrite  out  1  PC update enable.
- IFID_Write  out  1  IF/ID capture enable.
- IFID_Flush  out  1  IF/ID clear to NOP.
- IDEX_Write  out  1  ID/EX capture enable.
- IDEX_Flush  out  1  ID/EX clear to bubble.
- EXMEM_Write  out  1  EX/MEM capture enable.
- MEMWB_Bubble  out  1  force RegWrite/MemToReg = 0 into MEM/WB.
- MemTimeout  out  1  sticky: a wait reached MAX_WAIT.
- StallCycles  out  CNT_W  saturating count of freeze plus load-use stall cycles.
- FlushCount  out  CNT_W  saturating count of branch flushes.

## Operation
- FSM states: RUN, WAIT. Reset state RUN.
- Freeze condition: (state == RUN and MEM_MemOp and !DMemReady) or (state == WAIT and !DMemReady).
- DMemReq = MEM_MemOp in RUN; 1 in WAIT.
- RUN to WAIT: MEM_MemOp and !DMemReady.
- WAIT to RUN: on the first cycle with DMemReady = 1. That cycle is not a freeze cycle.
- Freeze outputs:
  - PCWrite = IFID_Write = IDEX_Write = EXMEM_Write = 0.
  - MEMWB_Bubble = 1.
  - IFID_Flush = IDEX_Flush = 0.
  - Branch and load-use inputs are ignored while frozen.
- Branch (no freeze, EX_BranchTaken = 1):
  - IFID_Flush = 1, IDEX_Flush = 1.
  - All write enables = 1.
  - FlushCount increments.
- Load-use (no freeze, no branch):
  - Condition: EX_MemRead and EX_Rd != 0 and (EX_Rd == ID_Rs or (ID_UsesRt and EX_Rd == ID_Rt)).
  - PCWrite = IFID_Write = 0; IDEX_Flush = 1; IDEX_Write = EXMEM_Write = 1.
- Priority: freeze > branch > load-use. Branch together with load-use produces branch response only; no stall.
- Default (no event): all write enables = 1, flushes = 0, MEMWB_Bubble = 0.
- Wait counter:
  - Cleared on entry to WAIT; increments each WAIT cycle.
  - Saturates at MAX_WAIT.
  - Sets MemTimeout when it reaches MAX_WAIT.
  - MemTimeout clears only on reset. The FSM stays in WAIT regardless.
- StallCycles increments on every freeze or load-use cycle.
- All counters saturate at all-ones, with no wrap.

## Timing
- Control outputs are combinational from the current state and inputs, with zero-cycle latency. Registered state: FSM, wait counter, MemTimeout, counters.
- While Reset = 0 at an edge:
  - next state RUN; counters 0; MemTimeout 0.
  - Combinational outputs forced during Reset = 0: DMemReq = 0, all enables 0, flushes 0, MEMWB_Bubble = 1.
- Reset mid-WAIT abandons the request; DMemReq drops in the same cycle.
- Single-cycle memory: when DMemReady = 1 in the same cycle as MEM_MemOp, there is no stall and the FSM stays in RUN.
- Load-use stalls exactly one cycle, because the bubble removes the load from EX.
- DMemReq holds at 1 until the DMemReady cycle inclusive.

## Structure
- Shared package `pipeline_ctrl_pkg`:
  - FSM state typedef (RUN, WAIT).
  - REG_ZERO = 5'd0 constant.
- Sub-module `hazard_detect`: pure combinational load-use compare. Output: LoadUse.
- FSM, counters and output priority mux live in the top module.

## Test plan
- Load with EX_Rd = 5, ID_Rs = 5, DMemReady = 1 → one cycle PCWrite = 0, IFID_Write = 0, IDEX_Flush = 1; StallCycles = 1.
- EX_Rd = 0 with EX_MemRead, ID_Rs = 0 → no stall. Separately, ID_UsesRt = 0 with ID_Rt matching → no stall.
- MEM_MemOp with DMemReady low 3 cycles then high → 3 freeze cycles with MEMWB_Bubble = 1 and DMemReq = 1 for 4 cycles; StallCycles = 3; state returns to RUN.
- EX_BranchTaken and load-use in the same cycle → IFID_Flush = IDEX_Flush = 1, PCWrite = 1; FlushCount = 1; StallCycles unchanged.
- DMemReady held low for 20 cycles with MAX_WAIT = 16 → MemTimeout rises after 16 WAIT cycles and stays 1 after DMemReady; Reset = 0 clears it.
- Reset = 0 asserted during WAIT → next cycle state RUN, counters 0, DMemReq = 0.
